// File: rtl/flash_fetch_pkg.sv
// Shared state encoding and constants for the flash burst fetcher.
// The dump base address is where the top-level controller starts a full flash dump.
package flash_fetch_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int LEN_W_DEF  = 16;

    localparam logic [23:0] DUMP_BASE_ADDR = 24'h400000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN,
        ST_ABORTING
    } fetch_state_e;

endpackage

// File: rtl/flash_burst_fetcher_if.sv
// Bus bundle for the fetcher: the read port toward dspi_flash_reader and the
// byte stream toward the UART transmitter. The fetcher is the master side.
interface flash_burst_fetcher_if
    import flash_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              rd_read;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic [7:0]        rd_data;

    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready;

    modport master (
        output rd_read, rd_addr, out_valid, out_data,
        input  rd_ready, rd_data, out_ready
    );

    modport slave (
        input  rd_read, rd_addr, out_valid, out_data,
        output rd_ready, rd_data, out_ready
    );

endinterface

// File: rtl/flash_burst_fetcher_byte_fifo.sv
// First-word-fall-through byte FIFO with flush and occupancy output.
// Flush has priority over a simultaneous push or pop.
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   pop_valid,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             do_pop;
    logic             full;

    assign full      = (count_q == LVL_W'(DEPTH));
    assign pop_valid = (count_q != '0);
    assign pop_data  = mem_q[rd_ptr_q];
    assign level     = count_q;
    assign do_pop    = pop && pop_valid;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count_d = count_q + LVL_W'(1);
                2'b01:   count_d = count_q - LVL_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is readable until the count says so.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Room is reserved before a read is issued, so a full FIFO never sees a push.
    assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/flash_burst_fetcher.sv
// Issues single-byte reads to the flash reader for a whole burst and buffers the
// returned bytes so a slow UART consumer can drain them as a valid/ready stream.
module flash_burst_fetcher
    import flash_fetch_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      start_addr,
    input  logic [LEN_W-1:0]       length,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] level,
    flash_burst_fetcher_if.master  bus
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_read_q, rd_read_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              fifo_valid;
    logic [7:0]        fifo_data;

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.rd_read   = rd_read_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_valid = fifo_valid;
    assign bus.out_data  = fifo_data;
    assign fifo_pop      = fifo_valid && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_read_d   = 1'b0;
        rd_addr_d   = rd_addr_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d     = ST_ISSUE;
                        busy_d      = 1'b1;
                        cur_addr_d  = start_addr;
                        remaining_d = length;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    fifo_flush  = 1'b1;
                    busy_d      = 1'b0;
                    remaining_d = '0;
                    state_d     = ST_IDLE;
                end else if (level < LVL_W'(DEPTH)) begin
                    rd_read_d = 1'b1;
                    rd_addr_d = cur_addr_q;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An abort that coincides with the reply can finish right away.
                if (abort) begin
                    if (bus.rd_ready) begin
                        fifo_flush  = 1'b1;
                        busy_d      = 1'b0;
                        remaining_d = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_ABORTING;
                    end
                end else if (bus.rd_ready) begin
                    fifo_push   = 1'b1;
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    state_d     = (remaining_q == LEN_W'(1)) ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    fifo_flush = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else if (level == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_ABORTING: begin
                if (bus.rd_ready) begin
                    fifo_flush  = 1'b1;
                    busy_d      = 1'b0;
                    remaining_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_read_q   <= 1'b0;
            rd_addr_q   <= '0;
            cur_addr_q  <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_read_q   <= rd_read_d;
            rd_addr_q   <= rd_addr_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (bus.rd_data),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .pop_valid (fifo_valid),
        .pop_data  (fifo_data),
        .level     (level)
    );

endmodule

// File: doc/flash_burst_fetcher.md
Name: flash_burst_fetcher

Overview:
- Sits between the top-level control FSM and dspi_flash_reader. Takes a start address and byte count, and issues back-to-back single-byte reads to the flash reader.
- Buffers returned bytes in a small FIFO and presents them as a valid/ready byte stream to uart_tx_hex or uart_tx.
- Decouples slow UART drain from flash read latency so a whole dump runs from one command.

Parameters:
- DEPTH, 16, FIFO depth in bytes; power of two, ≥2.
- ADDR_W, 24, flash byte address width.
- LEN_W, 16, burst length counter width.

Ports:
- clk  in  1  system clock (27 MHz); also drives the reader's sclk.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  ADDR_W  first byte address; sampled with start.
- length  in  LEN_W  number of bytes to fetch; sampled with start.
- abort  in  1  cancel current burst; ignored in IDLE.
- busy  out  1  high from accepted start until done or abort completes.
- done  out  1  one-cycle pulse after the last byte of a full burst leaves the output stream.
- rd_read  out  1  one-cycle read strobe to dspi_flash_reader.
- rd_addr  out  ADDR_W  address to the reader; held stable from rd_read until rd_ready.
- rd_ready  in  1  one-cycle pulse from the reader; rd_data valid in the same cycle.
- rd_data  in  8  byte from the reader.
- out_valid  out  1  output byte available.
- out_data  out  8  output byte; stable while out_valid && !out_ready.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, remaining count 0.
- FSM states:
  - IDLE: on start with length≠0, latch the address, set remaining=length, set busy, go to ISSUE. On start with length=0, pulse done on the next cycle and never raise busy.
  - ISSUE: if level + 0 in-flight < DEPTH, pulse rd_read for one cycle with rd_addr=cur_addr, then go to WAIT. Otherwise stay in ISSUE, which is the backpressure path.
  - WAIT: on rd_ready, push rd_data into the FIFO, cur_addr+1 (wraps 0xFFFFFF→0x000000 modulo 2^ADDR_W), remaining-1. If remaining becomes 0, go to DRAIN; else go to ISSUE.
  - DRAIN: when the FIFO is empty, pulse done, clear busy, return to IDLE.
  - ABORTING: wait for the outstanding rd_ready and discard its data. Flush the FIFO, clear busy, go to IDLE. done is not pulsed.
- One read in flight at most. Read throughput is one byte per (reader latency + 2) cycles.
- Room is reserved at issue time, so a push never finds the FIFO full. A push when full is an assertion failure.
- FIFO is first-word-fall-through:
  - Byte pushed at cycle N is visible on out_valid/out_data at N+1 if the FIFO was empty.
  - A push and a pop in the same cycle leave level unchanged.
  - Pop while empty is impossible because pops are gated by out_valid.
- rd_ready outside WAIT/ABORTING (e.g. after a reset mid-read, since the reader has no reset) is ignored; no push occurs.
- abort:
  - In ISSUE with nothing in flight, go straight to flush and IDLE on the next cycle.
  - In WAIT, go to ABORTING.
  - In DRAIN, flush immediately.
  - abort in the same cycle as start in IDLE: start wins, abort is ignored.
- start while busy: ignored, with no effect on the current burst.
- rst mid-burst: all state is cleared within the same clock, the FIFO is emptied, and out_valid drops next cycle.

Decomposition:
- Package flash_fetch_pkg:
  - FSM state encoding (IDLE, ISSUE, WAIT, DRAIN, ABORTING).
  - ADDR_W/LEN_W defaults.
  - Flash dump base address constant 24'h400000.
- Sub-module byte_fifo (DEPTH, 8-bit, FWFT, push/pop/flush/level). Reusable later for a uart_rx input buffer.

Test Plan:
- Length 4 from 0x400000, out_ready always 1, reader model 30-cycle latency:
  - rd_addr sequence is 400000, 400001, 400002, 400003.
  - Four stream bytes match the model memory.
  - done pulses exactly once, busy falls the same cycle.
- Length 40, out_ready held 0:
  - Exactly 16 rd_read pulses, then none.
  - level saturates at 16.
  - Releasing out_ready completes all 40 bytes in order.
- Start at 0xFFFFFE, length 3: rd_addr sequence FFFFFE, FFFFFF, 000000.
- Length 0: done pulses one cycle after start; busy, rd_read and out_valid stay 0.
- Abort while in WAIT with 3 bytes buffered:
  - The pending rd_ready is consumed, the FIFO is flushed, level=0.
  - No done pulse.
  - The next start of 2 bytes works normally.
- rst asserted during WAIT, stray rd_ready 10 cycles later: no push, level stays 0, out_valid stays 0.
